// File: rtl/mem_copy_pkg.sv
// Shared types and default sizes for the block-copy engine.
// Provides state_e (IDLE/COPY/DRAIN/DONE) and DW_DEF/AW_DEF.
package mem_copy_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COPY  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Memory-side bus of the copy engine: source read port, dest write port.
// master = engine (src_a, dst_we, dst_a, dst_wd out; src_rd in).
interface mem_copy_engine_if
  import mem_copy_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) ();

  logic [AW-1:0] src_a;
  logic [DW-1:0] src_rd;
  logic          dst_we;
  logic [AW-1:0] dst_a;
  logic [DW-1:0] dst_wd;

  modport master (
    output src_a,
    output dst_we,
    output dst_a,
    output dst_wd,
    input  src_rd
  );

  modport slave (
    input  src_a,
    input  dst_we,
    input  dst_a,
    input  dst_wd,
    output src_rd
  );

endinterface

// File: rtl/mem_copy_engine.sv
// Block-copy DMA: copies len words src_base.. -> dst_base.., one per cycle.
// Ports: clk, rst_n, start, abort, src_base, dst_base, len, busy, done,
// count, bus (master). MEM_COPY_FILL_EN adds fill/fill_val (constant fill).
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  input  logic [LW-1:0] len,
`ifdef MEM_COPY_FILL_EN
  input  logic          fill,
  input  logic [DW-1:0] fill_val,
`endif
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] count,
  mem_copy_engine_if.master bus
);

  state_e        state, state_d;
  logic [AW-1:0] src_ptr, dst_ptr, src_a_q;
  logic [LW-1:0] rd_rem;
  logic          we_q;
  logic [AW-1:0] wa_q;
  logic [DW-1:0] wd_q;
  logic          reading, rd_src;
  logic [DW-1:0] wdata;

  assign reading = (state == COPY)
                 && (rd_rem != '0) && !abort;

`ifdef MEM_COPY_FILL_EN
  logic          fill_q;
  logic [DW-1:0] fill_val_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q     <= 1'b0;
      fill_val_q <= '0;
    end else if (state == IDLE && start) begin
      fill_q     <= fill;
      fill_val_q <= fill_val;
    end
  end

  assign rd_src = reading && !fill_q;
  assign wdata  = fill_q ? fill_val_q : bus.src_rd;
`else
  assign rd_src = reading;
  assign wdata  = bus.src_rd;
`endif

  // src_a shows the live pointer only while reading; otherwise the
  // last address actually read stays on the bus.
  assign bus.src_a  = rd_src ? src_ptr : src_a_q;
  assign bus.dst_we = we_q;
  assign bus.dst_a  = wa_q;
  assign bus.dst_wd = wd_q;

  assign busy = (state == COPY) || (state == DRAIN);
  assign done = (state == DONE);

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (start) state_d = COPY;
      COPY: begin
        // len=0 has nothing to drain, so it skips straight to DONE.
        if (rd_rem == '0)
          state_d = DONE;
        else if (abort)
          state_d = DRAIN;
        else if (rd_rem == LW'(1))
          state_d = DRAIN;
      end
      DRAIN: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_ptr <= '0;
      dst_ptr <= '0;
      src_a_q <= '0;
      rd_rem  <= '0;
      count   <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      we_q <= reading;
      if (state == IDLE && start) begin
        src_ptr <= src_base;
        dst_ptr <= dst_base;
        rd_rem  <= len;
        count   <= '0;
      end
      if (reading) begin
        wd_q    <= wdata;
        wa_q    <= dst_ptr;
        src_ptr <= src_ptr + AW'(1);
        dst_ptr <= dst_ptr + AW'(1);
        rd_rem  <= rd_rem - LW'(1);
      end
      if (rd_src) src_a_q <= src_ptr;
      if (we_q)   count   <= count + LW'(1);
    end
  end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
Parametrised block-copy engine between two word-addressed memories with combinational read and synchronous write (mem32-style).
- On a start pulse it copies LEN consecutive words from a source region to a destination region, one word per cycle, through a one-stage read-data register.
- Reports busy, done and words-written.
- Sits beside data memories as a small DMA, replacing hard-wired memory-to-memory copy wiring.

Parameters:
DW, 32, data word width
AW, 5, address width; memory depth 2**AW words
LW, AW+1, length/count width; allows a full 2**AW-word copy

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  start request, sampled in IDLE only
abort  in  1  stop issuing reads; in-flight write still completes
src_base  in  AW  first source address
dst_base  in  AW  first destination address
len  in  LW  words to copy; 0 legal
busy  out  1  high from the cycle after accepted start until the last write strobe
done  out  1  one-cycle pulse after completion or abort
count  out  LW  words written in the current or last transfer
src_a  out  AW  source read address
src_rd  in  DW  source read data, combinational from src_a
dst_we  out  1  destination write enable
dst_a  out  AW  destination write address
dst_wd  out  DW  destination write data

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, count=0, dst_we=0, dst_a=0, dst_wd=0, src_a=0.
  - All pointers and counters are 0.
- States:
  - IDLE -> COPY on start.
  - COPY -> DRAIN when no reads remain, or when abort is high.
  - DRAIN -> DONE when no write is pending.
  - DONE -> IDLE unconditionally; done=1 only in DONE.
- Start (cycle 0, IDLE, start=1):
  - Latch src_ptr=src_base, dst_ptr=dst_base, rd_rem=len.
  - Clear count.
- COPY, each cycle with rd_rem>0 and abort=0:
  - src_a=src_ptr.
  - At the edge, capture src_rd into registered dst_wd, dst_a=dst_ptr, dst_we=1.
  - Increment src_ptr and dst_ptr; decrement rd_rem.
- Write strobes:
  - dst_we is registered, so the write of word k is presented in cycle k+2 and commits at that cycle's edge.
  - count increments at each edge where dst_we=1.
- Latency for len=N>0:
  - busy=1 in cycles 1..N+1.
  - dst_we=1 in cycles 2..N+1.
  - done=1 in cycle N+2.
  - Back-to-back start is accepted in cycle N+3.
- len=0: busy=1 in cycle 1 only, no write strobe, done in cycle 2, count=0.
- Address arithmetic: pointers wrap modulo 2**AW; a copy crossing the top address continues at 0.
- Abort:
  - Asserted in COPY cycle c: no read in cycle c.
  - A write captured at edge c-1 still strobes in cycle c.
  - done follows; count = words actually written.
  - Abort is ignored in IDLE and DONE.
- start while busy or in DONE: ignored, with no effect on the transfer.
- src_a when not reading: holds its last value. dst_we=0 outside write cycles.
- Overlap:
  - Defined only for disjoint regions or dst_base <= src_base (forward copy).
  - Other overlaps are the caller's responsibility.
- Reset mid-transfer: immediate return to reset values; no further writes; no done.

Optional Feature:
Macro MEM_COPY_FILL_EN.
- Defined:
  - Adds input fill (1 bit, latched at start) and fill_val (DW bits, latched at start).
  - With fill=1: no source reads (src_a held), dst_wd=fill_val for every word, identical timing and count.
- Undefined: ports absent; copy only.

Decomposition:
- Package mem_copy_pkg:
  - State enum typedef (IDLE, COPY, DRAIN, DONE).
  - Default DW/AW constants.
- No sub-module is needed; the engine is one FSM plus pointer and counter registers.
- The bench instantiates two mem32-style memories (source and destination) around it.

Test Plan:
- Src preloaded with 0x1000+i; start, src_base=3, dst_base=10, len=4 -> dst[10..13]=0x1003..0x1006, dst_we high cycles 2..5, done in cycle 6, count=4.
- len=0 -> no dst_we, busy one cycle, done in cycle 2, count=0.
- Wrap: src_base=30, dst_base=29, len=4, AW=5 -> reads 30,31,0,1; writes 29,30,31,0; dst[0]=src[1].
- Abort asserted in the 3rd COPY cycle of len=8 -> exactly 2 words written, done next after drain, count=2, dst[dst_base+2..] untouched.
- start pulsed during busy, then rst_n=0 mid-copy -> second start ignored; outputs return to 0 asynchronously, no done, and the next start after reset runs cleanly.
- MEM_COPY_FILL_EN: fill=1, fill_val=0xDEADBEEF, len=5 -> 5 words of 0xDEADBEEF at dst, src_a unchanged, done in cycle 7.
